// File: rtl/cl_decode_pipe.sv
// cl_decode_pipe: a registered decode stage between fetch and execute.
// It holds a load-use hazard scoreboard. Each accepted instruction is decoded
// into memory and register-file control flags. The instruction and its flags
// are held in one output register. Acceptance stalls while a source register
// matches the destination of a load that is still in flight.
//
// Ports:
//   clk, n_reset      clock; asynchronous active-low reset
//   valid_i / ready_o / instruction_i    fetch-side handshake and instruction
//   valid_o / ready_i / instruction_o    execute-side handshake and registered instruction
//   is_load_op_o, is_store_op_o, is_mem_op_o, is_byte_op_o, op_writes_rf_o
//                     decoded flags; these are zero whenever valid_o is low
//   flush_i           kills the output register and blocks acceptance this cycle
//   stall_cnt_o       saturating count of hazard-stall cycles

package cl_decode_pkg;
  localparam int unsigned OPCODE_W = 5;
  localparam int unsigned REG_W    = 5;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rs_imm;
  } instruction_s;

  localparam logic [OPCODE_W-1:0] kADDU = 5'd0;
  localparam logic [OPCODE_W-1:0] kSUBU = 5'd1;
  localparam logic [OPCODE_W-1:0] kSLLV = 5'd2;
  localparam logic [OPCODE_W-1:0] kSRAV = 5'd3;
  localparam logic [OPCODE_W-1:0] kSRLV = 5'd4;
  localparam logic [OPCODE_W-1:0] kAND  = 5'd5;
  localparam logic [OPCODE_W-1:0] kOR   = 5'd6;
  localparam logic [OPCODE_W-1:0] kNOR  = 5'd7;
  localparam logic [OPCODE_W-1:0] kSLT  = 5'd8;
  localparam logic [OPCODE_W-1:0] kSLTU = 5'd9;
  localparam logic [OPCODE_W-1:0] kMOV  = 5'd10;
  localparam logic [OPCODE_W-1:0] kJALR = 5'd11;
  localparam logic [OPCODE_W-1:0] kLW   = 5'd12;
  localparam logic [OPCODE_W-1:0] kLBU  = 5'd13;
  localparam logic [OPCODE_W-1:0] kSW   = 5'd14;
  localparam logic [OPCODE_W-1:0] kSB   = 5'd15;
  localparam logic [OPCODE_W-1:0] kBEQZ = 5'd16;
  localparam logic [OPCODE_W-1:0] kBNEZ = 5'd17;
  localparam logic [OPCODE_W-1:0] kJ    = 5'd18;
  localparam logic [OPCODE_W-1:0] kNOP  = 5'd19;
endpackage

module cl_decode_pipe
  import cl_decode_pkg::*;
#(
  parameter int unsigned RF_ADDR_W     = REG_W,
  parameter int unsigned LOAD_LAT      = 2,
  parameter bit          ZERO_REG_HARD = 1'b1
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         valid_i,
  input  instruction_s instruction_i,
  output logic         ready_o,
  output logic         valid_o,
  input  logic         ready_i,
  output instruction_s instruction_o,
  output logic         is_load_op_o,
  output logic         is_store_op_o,
  output logic         is_mem_op_o,
  output logic         is_byte_op_o,
  output logic         op_writes_rf_o,
  input  logic         flush_i,
  output logic [15:0]  stall_cnt_o
);

  typedef struct packed {
    logic is_load;
    logic is_store;
    logic is_mem;
    logic is_byte;
    logic writes_rf;
  } flags_s;

  function automatic flags_s decode_op(input logic [OPCODE_W-1:0] op);
    flags_s f;
    f = '0;
    casez (op)
      kLW:  begin f.is_load = 1'b1; f.is_mem = 1'b1; f.writes_rf = 1'b1; end
      kLBU: begin f.is_load = 1'b1; f.is_mem = 1'b1; f.writes_rf = 1'b1; f.is_byte = 1'b1; end
      kSW:  begin f.is_store = 1'b1; f.is_mem = 1'b1; end
      kSB:  begin f.is_store = 1'b1; f.is_mem = 1'b1; f.is_byte = 1'b1; end
      kADDU, kSUBU, kSLLV, kSRAV, kSRLV, kAND, kOR, kNOR,
      kSLT, kSLTU, kMOV, kJALR: f.writes_rf = 1'b1;
      default: f = '0;
    endcase
    return f;
  endfunction

  // Register 0 is hardwired, so with ZERO_REG_HARD a match on it never blocks.
  function automatic logic addr_hit(input logic [RF_ADDR_W-1:0] src,
                                    input logic [RF_ADDR_W-1:0] dst);
    return (src == dst) && !(ZERO_REG_HARD && (dst == '0));
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  instruction_s          instr_p1;
  flags_s                flags_p1;
  logic                  vld_p1;
  logic [LOAD_LAT-1:0]   sb_v;
  logic [RF_ADDR_W-1:0]  sb_addr [LOAD_LAT];
  logic [15:0]           stall_cnt;

  flags_s                dec_flags;
  logic                  hazard;
  logic                  accept;
  logic                  xfer_out;
  logic [RF_ADDR_W-1:0]  src_rd;
  logic [RF_ADDR_W-1:0]  src_rs;

  assign dec_flags = decode_op(instruction_i.opcode);
  assign src_rd    = instruction_i.rd;
  assign src_rs    = instruction_i.rs_imm;

  // Both fields are treated as sources for every opcode. This is
  // conservative but avoids a per-opcode operand table. The output-register
  // term covers a load that is departing in this same cycle, so a dependent
  // instruction directly behind a load always stalls.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (sb_v[i] && (addr_hit(src_rd, sb_addr[i]) || addr_hit(src_rs, sb_addr[i])))
        hazard = 1'b1;
    end
    if (vld_p1 && flags_p1.is_load &&
        (addr_hit(src_rd, instr_p1.rd) || addr_hit(src_rs, instr_p1.rd)))
      hazard = 1'b1;
    hazard = hazard & valid_i;
  end

  assign xfer_out = vld_p1 & ready_i;
  assign ready_o  = ~hazard & (~vld_p1 | ready_i) & ~flush_i;
  assign accept   = valid_i & ready_o;

  // Stage p0 -> p1: output register, scoreboard valid bits and stall counter.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      vld_p1    <= 1'b0;
      instr_p1  <= '0;
      flags_p1  <= '0;
      sb_v      <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush_i)       vld_p1 <= 1'b0;
      else if (accept)   vld_p1 <= 1'b1;
      else if (xfer_out) vld_p1 <= 1'b0;

      if (accept) begin
        instr_p1 <= instruction_i;
        flags_p1 <= dec_flags;
      end

      // A load is recorded when it leaves the stage, including under flush.
      // Loads that have already issued cannot be recalled.
      for (int i = LOAD_LAT - 1; i > 0; i--) sb_v[i] <= sb_v[i-1];
      sb_v[0] <= xfer_out & flags_p1.is_load;

      if (hazard) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  // The scoreboard addresses are only meaningful alongside their valid bits.
  always_ff @(posedge clk) begin
    for (int i = LOAD_LAT - 1; i > 0; i--) sb_addr[i] <= sb_addr[i-1];
    sb_addr[0] <= instr_p1.rd;
  end

  assign valid_o        = vld_p1;
  assign instruction_o  = instr_p1;
  assign is_load_op_o   = vld_p1 & flags_p1.is_load;
  assign is_store_op_o  = vld_p1 & flags_p1.is_store;
  assign is_mem_op_o    = vld_p1 & flags_p1.is_mem;
  assign is_byte_op_o   = vld_p1 & flags_p1.is_byte;
  assign op_writes_rf_o = vld_p1 & flags_p1.writes_rf;
  assign stall_cnt_o    = stall_cnt;

endmodule

// File: tb/tb_cl_decode_pipe.sv
module tb_cl_decode_pipe;
  import cl_decode_pkg::*;

  localparam int LOAD_LAT = 2;

  logic         clk = 1'b0;
  logic         n_reset;
  logic         valid_i;
  instruction_s instruction_i;
  logic         ready_o;
  logic         valid_o;
  logic         ready_i;
  instruction_s instruction_o;
  logic         is_load_op_o, is_store_op_o, is_mem_op_o, is_byte_op_o, op_writes_rf_o;
  logic         flush_i;
  logic [15:0]  stall_cnt_o;

  int vectors = 0;
  int miscompares = 0;

  cl_decode_pipe #(.RF_ADDR_W(5), .LOAD_LAT(LOAD_LAT), .ZERO_REG_HARD(1'b1)) dut (
    .clk(clk), .n_reset(n_reset), .valid_i(valid_i), .instruction_i(instruction_i),
    .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready_i), .instruction_o(instruction_o),
    .is_load_op_o(is_load_op_o), .is_store_op_o(is_store_op_o), .is_mem_op_o(is_mem_op_o),
    .is_byte_op_o(is_byte_op_o), .op_writes_rf_o(op_writes_rf_o), .flush_i(flush_i),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model. Each register carries a countdown of cycles for which it
  // is still blocked by a departed load. The countdown is kept per register
  // rather than as a pipeline of slots.
  logic         m_valid;
  instruction_s m_instr;
  int           blocked [32];
  int           m_stall;

  function automatic logic is_ld(input logic [4:0] op);
    return op == kLW || op == kLBU;
  endfunction

  // Flag order is {load, store, mem, byte, writes_rf}.
  function automatic logic [4:0] exp_flags(input logic [4:0] op);
    logic ld, st, by, wr;
    ld = is_ld(op);
    st = (op == kSW) || (op == kSB);
    by = (op == kLBU) || (op == kSB);
    wr = ld || (op <= kJALR);
    return {ld, st, ld | st, by, wr};
  endfunction

  function automatic logic src_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    return (blocked[a] > 0) || (m_valid && is_ld(m_instr.opcode) && m_instr.rd == a);
  endfunction

  function automatic logic m_hazard();
    return valid_i && (src_busy(instruction_i.rd) || src_busy(instruction_i.rs_imm));
  endfunction

  function automatic logic m_ready();
    return !m_hazard() && (!m_valid || ready_i) && !flush_i;
  endfunction

  always @(posedge clk) begin
    if (!n_reset) begin
      m_valid = 1'b0;
      m_instr = '0;
      m_stall = 0;
      for (int r = 0; r < 32; r++) blocked[r] = 0;
    end else begin
      logic hz, acc, xf;
      hz  = m_hazard();
      acc = valid_i && m_ready();
      xf  = m_valid && ready_i;
      for (int r = 0; r < 32; r++) if (blocked[r] > 0) blocked[r]--;
      if (xf && is_ld(m_instr.opcode)) blocked[m_instr.rd] = LOAD_LAT;
      if (hz && m_stall < 65535) m_stall++;
      if (flush_i) m_valid = 1'b0;
      else if (acc) begin m_valid = 1'b1; m_instr = instruction_i; end
      else if (xf) m_valid = 1'b0;
    end
  end

  // One compare process: checks every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!n_reset) begin
      chk("rst_valid_o", valid_o, 0);
      chk("rst_flags", {is_load_op_o, is_store_op_o, is_mem_op_o, is_byte_op_o, op_writes_rf_o}, 0);
      chk("rst_instruction_o", instruction_o, 0);
      chk("rst_stall_cnt", stall_cnt_o, 0);
    end else begin
      chk("ready_o", ready_o, m_ready());
      chk("valid_o", valid_o, m_valid);
      chk("stall_cnt_o", stall_cnt_o, m_stall);
      chk("flags", {is_load_op_o, is_store_op_o, is_mem_op_o, is_byte_op_o, op_writes_rf_o},
          m_valid ? exp_flags(m_instr.opcode) : 5'd0);
      if (m_valid) chk("instruction_o", instruction_o, m_instr);
    end
  end

  function automatic instruction_s mk(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs);
    instruction_s x;
    x.opcode = op; x.rd = rd; x.rs_imm = rs;
    return x;
  endfunction

  task automatic drive(input logic v, input instruction_s ins, input logic rdy, input logic fl);
    valid_i = v; instruction_i = ins; ready_i = rdy; flush_i = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    int s0;
    n_reset = 1'b0;
    drive(1'b1, mk(kADDU, 5'd1, 5'd2), 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #2 n_reset = 1'b1;
    #1;
    chk("lit_ready_after_reset", ready_o, 1);
    chk("lit_valid_after_reset", valid_o, 0);

    // ADDU then SW stream with no stall.
    next_cycle(); drive(1'b1, mk(kSW, 5'd3, 5'd4), 1'b1, 1'b0);
    @(negedge clk);
    chk("lit_addu_instr", instruction_o, mk(kADDU, 5'd1, 5'd2));
    chk("lit_addu_wr", op_writes_rf_o, 1);
    chk("lit_addu_mem", is_mem_op_o, 0);
    next_cycle(); drive(1'b0, mk(kNOP, 5'd0, 5'd0), 1'b1, 1'b0);
    @(negedge clk);
    chk("lit_sw_store", is_store_op_o, 1);
    chk("lit_sw_mem", is_mem_op_o, 1);
    chk("lit_sw_wr", op_writes_rf_o, 0);
    chk("lit_no_stall", stall_cnt_o, 0);

    // LW r5 followed by a reader of r5: three stall cycles.
    next_cycle(); drive(1'b1, mk(kLW, 5'd5, 5'd0), 1'b1, 1'b0);
    @(negedge clk);
    s0 = stall_cnt_o;
    next_cycle(); drive(1'b1, mk(kADDU, 5'd6, 5'd5), 1'b1, 1'b0);
    @(negedge clk); chk("lit_lw_out_stall", ready_o, 0);
    for (int k = 0; k < 2; k++) begin
      next_cycle(); @(negedge clk); chk("lit_lw_sb_stall", ready_o, 0);
    end
    next_cycle(); @(negedge clk);
    chk("lit_lw_released", ready_o, 1);
    chk("lit_lw_stall_cnt", stall_cnt_o - 16'(s0), 3);

    // LBU r0 followed by a reader of r0: no stall.
    next_cycle(); drive(1'b1, mk(kLBU, 5'd0, 5'd0), 1'b1, 1'b0);
    next_cycle(); drive(1'b1, mk(kADDU, 5'd1, 5'd0), 1'b1, 1'b0);
    @(negedge clk);
    chk("lit_lbu_byte", is_byte_op_o, 1);
    chk("lit_lbu_load", is_load_op_o, 1);
    chk("lit_r0_no_stall", ready_o, 1);

    // Backpressure for three cycles, then a no-bubble replacement.
    next_cycle(); drive(1'b1, mk(kOR, 5'd2, 5'd3), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lit_bp_ready", ready_o, 0);
      chk("lit_bp_hold", instruction_o, mk(kADDU, 5'd1, 5'd0));
      next_cycle();
    end
    ready_i = 1'b1;
    @(negedge clk); chk("lit_bp_release", ready_o, 1);
    next_cycle(); drive(1'b1, mk(kLW, 5'd7, 5'd0), 1'b1, 1'b0);
    @(negedge clk);
    chk("lit_no_bubble_instr", instruction_o, mk(kOR, 5'd2, 5'd3));
    chk("lit_no_bubble_valid", valid_o, 1);

    // LW r7 leaves under flush and must still block r7 readers.
    next_cycle(); drive(1'b0, mk(kNOP, 5'd0, 5'd0), 1'b1, 1'b1);
    @(negedge clk); chk("lit_flush_ready", ready_o, 0);
    next_cycle(); drive(1'b1, mk(kADDU, 5'd1, 5'd7), 1'b1, 1'b0);
    @(negedge clk);
    chk("lit_flush_valid", valid_o, 0);
    chk("lit_flush_sb_stall0", ready_o, 0);
    next_cycle(); @(negedge clk); chk("lit_flush_sb_stall1", ready_o, 0);
    next_cycle(); @(negedge clk); chk("lit_flush_sb_release", ready_o, 1);

    // Randomized traffic with small register numbers to provoke hazards.
    for (int n = 0; n < 4000; n++) begin
      next_cycle();
      drive($urandom_range(0, 9) < 7,
            mk(5'($urandom_range(0, 19)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))),
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      if (n == 2500) begin
        n_reset = 1'b0;
        repeat (2) next_cycle();
        n_reset = 1'b1;
      end
    end
    next_cycle(); drive(1'b0, mk(kNOP, 5'd0, 5'd0), 1'b1, 1'b0);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
